// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the F/D and D/E registers of the 5-stage pipeline.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_count counters.
module pipeline_hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MDU_CYCLES        = 4,
   parameter int CNT_W             = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_stall,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic       uses_rs_d,
   input  logic       uses_rt_d,
   input  logic       mdu_start_d,
   input  logic [4:0] rd_e,
   input  logic       reg_write_e,
   input  logic       mem_to_reg_e,
   input  logic       branch_taken_e,
   output logic       en_fd,
   output logic       en_de,
   output logic       clr_fd,
   output logic       clr_de,
   output logic       mdu_busy,
   output logic       mdu_done
`ifdef HAZARD_PERF_EN
  ,output logic [31:0] stall_cycles
  ,output logic [15:0] flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN,
      LDSTALL,
      MDU
   } state_e;

   localparam logic [CNT_W-1:0] LD_INIT =
      CNT_W'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] MDU_INIT = CNT_W'(MDU_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic hit_rs, hit_rt, lu;

   assign hit_rs = uses_rs_d & (rs_d == rd_e);
   assign hit_rt = uses_rt_d & (rt_d == rd_e);
   assign lu     = mem_to_reg_e & reg_write_e & (rd_e != 5'd0)
                 & (hit_rs | hit_rt);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      en_fd    = 1'b1;
      en_de    = 1'b1;
      clr_fd   = 1'b0;
      clr_de   = 1'b0;
      mdu_busy = 1'b0;
      mdu_done = 1'b0;

      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               en_fd = 1'b0;
               en_de = 1'b0;
            end else if (branch_taken_e) begin
               clr_fd = 1'b1;
               clr_de = 1'b1;
            end else if (lu) begin
               en_fd  = 1'b0;
               clr_de = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_d = LDSTALL;
                  cnt_d   = LD_INIT;
               end
            end else if (mdu_start_d) begin
               state_d = MDU;
               cnt_d   = MDU_INIT;
            end
         end

         LDSTALL: begin
            en_fd = 1'b0;
            if (mem_stall) begin
               en_de = 1'b0;
            end else begin
               clr_de = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else cnt_d = cnt_q - 1'b1;
            end
         end

         MDU: begin
            en_fd    = 1'b0;
            mdu_busy = 1'b1;
            if (mem_stall) begin
               en_de = 1'b0;
            end else begin
               clr_de = 1'b1;
               if (cnt_q == '0) begin
                  mdu_done = 1'b1;
                  state_d  = RUN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      // Reset overrides every decision so the datapath sees a quiet control word.
      if (rst) begin
         en_fd    = 1'b0;
         en_de    = 1'b0;
         clr_fd   = 1'b0;
         clr_de   = 1'b0;
         mdu_busy = 1'b0;
         mdu_done = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!en_fd && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (clr_fd && (flush_q != '1)) flush_d = flush_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two hazard sequencers (1-cycle and 3-cycle load stall)
// share stimulus and are checked against a remaining-cycles reference model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_stall = 1'b0;
   logic [4:0] rs_d = '0, rt_d = '0, rd_e = '0;
   logic       uses_rs_d = 1'b0, uses_rt_d = 1'b0;
   logic       mdu_start_d = 1'b0;
   logic       reg_write_e = 1'b0, mem_to_reg_e = 1'b0;
   logic       branch_taken_e = 1'b0;

   logic a_en_fd, a_en_de, a_clr_fd, a_clr_de, a_busy, a_done;
   logic b_en_fd, b_en_de, b_clr_fd, b_clr_de, b_busy, b_done;
`ifdef HAZARD_PERF_EN
   logic [31:0] a_stall, b_stall;
   logic [15:0] a_flush, b_flush;
`endif

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .LOAD_STALL_CYCLES(1), .MDU_CYCLES(2), .CNT_W(4)
   ) u_a (
      .clk(clk), .rst(rst), .mem_stall(mem_stall),
      .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
      .mdu_start_d(mdu_start_d), .rd_e(rd_e),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
      .branch_taken_e(branch_taken_e),
      .en_fd(a_en_fd), .en_de(a_en_de),
      .clr_fd(a_clr_fd), .clr_de(a_clr_de),
      .mdu_busy(a_busy), .mdu_done(a_done)
`ifdef HAZARD_PERF_EN
     ,.stall_cycles(a_stall), .flush_count(a_flush)
`endif
   );

   pipeline_hazard_ctrl #(
      .LOAD_STALL_CYCLES(3), .MDU_CYCLES(4), .CNT_W(4)
   ) u_b (
      .clk(clk), .rst(rst), .mem_stall(mem_stall),
      .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
      .mdu_start_d(mdu_start_d), .rd_e(rd_e),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
      .branch_taken_e(branch_taken_e),
      .en_fd(b_en_fd), .en_de(b_en_de),
      .clr_fd(b_clr_fd), .clr_de(b_clr_de),
      .mdu_busy(b_busy), .mdu_done(b_done)
`ifdef HAZARD_PERF_EN
     ,.stall_cycles(b_stall), .flush_count(b_flush)
`endif
   );

   typedef struct {
      int          cyc;
      logic [5:0]  oa;
      logic [5:0]  ob;
      logic [31:0] sa;
      logic [31:0] sb;
      logic [15:0] fa;
      logic [15:0] fb;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Model: each instance only tracks how many stall cycles remain.
   int          lcyc[2] = '{1, 3};
   int          mcyc[2] = '{2, 4};
   int          ld_left[2]  = '{0, 0};
   int          mdu_left[2] = '{0, 0};
   logic [31:0] stall_m[2]  = '{0, 0};
   logic [15:0] flush_m[2]  = '{0, 0};

   function automatic logic [5:0] model(int i, logic lu);
      logic ef, ed, cf, cd, bz, dn;
      ef = 1; ed = 1; cf = 0; cd = 0; bz = 0; dn = 0;
      if (rst) begin
         ef = 0; ed = 0;
         ld_left[i] = 0;
         mdu_left[i] = 0;
      end else if (mdu_left[i] > 0) begin
         bz = 1; ef = 0;
         if (mem_stall) ed = 0;
         else begin
            cd = 1;
            dn = (mdu_left[i] == 1);
            mdu_left[i]--;
         end
      end else if (ld_left[i] > 0) begin
         ef = 0;
         if (mem_stall) ed = 0;
         else begin
            cd = 1;
            ld_left[i]--;
         end
      end else if (mem_stall) begin
         ef = 0; ed = 0;
      end else if (branch_taken_e) begin
         cf = 1; cd = 1;
      end else if (lu) begin
         ef = 0; cd = 1;
         ld_left[i] = lcyc[i] - 1;
      end else if (mdu_start_d) begin
         mdu_left[i] = mcyc[i];
      end
      return {ef, ed, cf, cd, bz, dn};
   endfunction

   task automatic push();
      exp_t e;
      logic lu;
      logic [5:0] o[2];
      lu = mem_to_reg_e && reg_write_e && (rd_e != 0) &&
           ((uses_rs_d && rs_d == rd_e) || (uses_rt_d && rt_d == rd_e));
      for (int i = 0; i < 2; i++) begin
         o[i] = model(i, lu);
         if (rst) begin
            stall_m[i] = 0;
            flush_m[i] = 0;
         end
      end
      e.cyc = cyc;
      e.oa = o[0]; e.ob = o[1];
      e.sa = stall_m[0]; e.sb = stall_m[1];
      e.fa = flush_m[0]; e.fb = flush_m[1];
      q.push_back(e);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            if (!o[i][5] && stall_m[i] != '1) stall_m[i]++;
            if (o[i][3] && flush_m[i] != '1) flush_m[i]++;
         end
      end
   endtask

   task automatic step(input logic r, ms, br, urs, urt, mdu, rw, m2r,
                       input logic [4:0] rs, rt, rd);
      @(posedge clk);
      #1;
      cyc++;
      rst = r; mem_stall = ms; branch_taken_e = br;
      uses_rs_d = urs; uses_rt_d = urt; mdu_start_d = mdu;
      reg_write_e = rw; mem_to_reg_e = m2r;
      rs_d = rs; rt_d = rt; rd_e = rd;
      push();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic chk(input string nm, input int c,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("outs_a", e.cyc,
             {26'd0, a_en_fd, a_en_de, a_clr_fd, a_clr_de, a_busy, a_done},
             {26'd0, e.oa});
         chk("outs_b", e.cyc,
             {26'd0, b_en_fd, b_en_de, b_clr_fd, b_clr_de, b_busy, b_done},
             {26'd0, e.ob});
`ifdef HAZARD_PERF_EN
         chk("stall_a", e.cyc, a_stall, e.sa);
         chk("stall_b", e.cyc, b_stall, e.sb);
         chk("flush_a", e.cyc, {16'd0, a_flush}, {16'd0, e.fa});
         chk("flush_b", e.cyc, {16'd0, b_flush}, {16'd0, e.fb});
`endif
      end
   end

   initial begin
      // reset, then idle
      step(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(10);
      // load-use on rs, then same with rd_e = 0
      step(0, 0, 0, 1, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5);
      idle(5);
      step(0, 0, 0, 1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
      idle(3);
      // load-use with memory stall inside the load bubbles
      step(0, 0, 0, 0, 1, 0, 1, 1, 5'd0, 5'd7, 5'd7);
      step(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(4);
      // multiply/divide issue
      step(0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(6);
      // branch + lu + mdu, then lu + mdu, then mdu held one more cycle
      step(0, 0, 1, 1, 0, 1, 1, 1, 5'd3, 5'd0, 5'd3);
      step(0, 0, 0, 1, 0, 1, 1, 1, 5'd3, 5'd0, 5'd3);
      step(0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(8);
      // reset in the middle of an MDU sequence
      step(0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle(6);
      // randomized traffic over a small register range to force collisions
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(299) == 0,
              $urandom_range(5) == 0,
              $urandom_range(7) == 0,
              1'($urandom_range(1)),
              1'($urandom_range(1)),
              $urandom_range(9) == 0,
              $urandom_range(3) != 0,
              $urandom_range(2) == 0,
              5'($urandom_range(3)),
              5'($urandom_range(3)),
              5'($urandom_range(3)));
      end
      idle(2);
      @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
